// File: rtl/td4_run_ctrl_if.sv
// Handshake bundle between board-side controls and the TD4 run/halt/step sequencer.
interface td4_run_ctrl_if;
  logic       run_req;
  logic       halt_req;
  logic       step_req;
  logic       speed_sel;
  logic [3:0] pc;
  logic [3:0] bp_addr;
  logic       bp_valid;
  logic       core_en;
  logic       running;
  logic       halted;
  logic [7:0] step_count;
  logic       bp_hit;

  modport master (
    output run_req, halt_req, step_req, speed_sel, pc, bp_addr, bp_valid,
    input  core_en, running, halted, step_count, bp_hit
  );

  modport slave (
    input  run_req, halt_req, step_req, speed_sel, pc, bp_addr, bp_valid,
    output core_en, running, halted, step_count, bp_hit
  );
endinterface

// File: rtl/td4_run_ctrl.sv
// Run/halt/single-step sequencer producing the one-cycle core clock-enable.
// Define TD4_BREAKPOINT_EN to enable the program-address breakpoint.
module td4_run_ctrl #(
  parameter int SLOW_DIV = 12_000_000,
  parameter int FAST_DIV = 1_200_000,
  parameter int CNT_W    = 24
) (
  input logic           clock,
  input logic           reset,
  td4_run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {ST_HALT, ST_RUN, ST_STEP} state_t;

  localparam logic [CNT_W-1:0] SLOW_M1 = CNT_W'(SLOW_DIV - 1);
  localparam logic [CNT_W-1:0] FAST_M1 = CNT_W'(FAST_DIV - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] limit_m1;
  logic             core_en_q;
  logic [7:0]       step_count_q;
  logic             fire;
  logic             run_go;
  logic             step_go;
  logic             halt_go;
  logic             bp_stop;
  logic             issue_run;
  logic             bp_trip;

  // Greater-or-equal compare so a mid-count switch to the shorter period fires at once.
  assign limit_m1  = bus.speed_sel ? FAST_M1 : SLOW_M1;
  assign fire      = (state == ST_RUN) && (cnt >= limit_m1);
  assign run_go    = (state == ST_HALT) && bus.run_req && !bus.halt_req;
  assign step_go   = (state == ST_HALT) && bus.step_req && !bus.run_req && !bus.halt_req;
  assign halt_go   = (state == ST_RUN) && bus.halt_req;
  assign issue_run = fire && !halt_go && !bp_stop;
  assign bp_trip   = fire && !halt_go && bp_stop;

`ifdef TD4_BREAKPOINT_EN
  logic armed;
  logic bp_hit_q;

  // armed lets a run that starts sitting on the breakpoint execute that instruction.
  assign bp_stop = bus.bp_valid && (bus.pc == bus.bp_addr) && !armed;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      armed    <= 1'b0;
      bp_hit_q <= 1'b0;
    end else if (run_go) begin
      armed    <= 1'b1;
      bp_hit_q <= 1'b0;
    end else if (step_go) begin
      bp_hit_q <= 1'b0;
    end else if (issue_run) begin
      armed    <= 1'b0;
    end else if (bp_trip) begin
      bp_hit_q <= 1'b1;
    end
  end

  assign bus.bp_hit = bp_hit_q;
`else
  logic bp_unused;

  assign bp_unused  = ^{bus.pc, bus.bp_addr, bus.bp_valid, bp_trip};
  assign bp_stop    = 1'b0;
  assign bus.bp_hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_HALT;
      cnt          <= '0;
      core_en_q    <= 1'b0;
      step_count_q <= 8'd0;
    end else begin
      core_en_q <= 1'b0;
      case (state)
        ST_HALT: begin
          if (run_go) begin
            state <= ST_RUN;
            cnt   <= '0;
          end else if (step_go) begin
            state        <= ST_STEP;
            core_en_q    <= 1'b1;
            step_count_q <= step_count_q + 8'd1;
          end
        end
        ST_STEP: begin
          state <= ST_HALT;
        end
        ST_RUN: begin
          if (halt_go) begin
            state <= ST_HALT;
            cnt   <= '0;
          end else if (fire) begin
            cnt <= '0;
            if (bp_stop) begin
              state <= ST_HALT;
            end else begin
              core_en_q    <= 1'b1;
              step_count_q <= step_count_q + 8'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_HALT;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.core_en    = core_en_q;
  assign bus.running    = (state == ST_RUN);
  assign bus.halted     = (state == ST_HALT);
  assign bus.step_count = step_count_q;

endmodule

// File: tb/tb_td4_run_ctrl.sv
// Randomized self-checking bench for td4_run_ctrl against a cycle-level behavioural model.
module tb_td4_run_ctrl;

  localparam int SLOW = 4;
  localparam int FAST = 2;

  typedef enum {M_HALT, M_RUN, M_STEP} mode_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  mode_t m_mode;
  int    m_since;
  int    m_count;
  int    m_pc;
  bit    m_en;
  bit    m_bp_hit;
  bit    m_armed;

  td4_run_ctrl_if intf ();

  td4_run_ctrl #(.SLOW_DIV(SLOW), .FAST_DIV(FAST), .CNT_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (intf.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_mode   = M_HALT;
    m_since  = 0;
    m_count  = 0;
    m_en     = 1'b0;
    m_bp_hit = 1'b0;
    m_armed  = 1'b0;
  endtask

  // One instruction-rate decision per clock edge, expressed as elapsed edges vs. period.
  task automatic modelStep();
    int limit;
    bit issue;
    limit = intf.speed_sel ? FAST : SLOW;
    issue = 1'b0;
    case (m_mode)
      M_HALT: begin
        if (intf.halt_req) begin
        end else if (intf.run_req) begin
          m_mode   = M_RUN;
          m_since  = 0;
          m_armed  = 1'b1;
          m_bp_hit = 1'b0;
        end else if (intf.step_req) begin
          m_mode   = M_STEP;
          issue    = 1'b1;
          m_bp_hit = 1'b0;
        end
      end
      M_STEP: m_mode = M_HALT;
      M_RUN: begin
        if (intf.halt_req) begin
          m_mode = M_HALT;
        end else begin
          m_since++;
          if (m_since >= limit) begin
            m_since = 0;
`ifdef TD4_BREAKPOINT_EN
            if (intf.bp_valid && intf.pc == intf.bp_addr && !m_armed) begin
              m_mode   = M_HALT;
              m_bp_hit = 1'b1;
            end else begin
              issue   = 1'b1;
              m_armed = 1'b0;
            end
`else
            issue = 1'b1;
`endif
          end
        end
      end
      default: m_mode = M_HALT;
    endcase
    if (issue) m_count = (m_count + 1) % 256;
    m_en = issue;
  endtask

  task automatic tick();
    bit prev_en;
    @(posedge clock);
    prev_en = m_en;
    modelStep();
    if (prev_en) m_pc = (m_pc + 1) % 16;
    @(negedge clock);
    intf.pc = 4'(m_pc);
    checkOutput("core_en", intf.core_en, m_en);
    checkOutput("running", intf.running, m_mode == M_RUN);
    checkOutput("halted", intf.halted, m_mode == M_HALT);
    checkOutput("step_count", intf.step_count, m_count);
    checkOutput("bp_hit", intf.bp_hit, m_bp_hit);
    intf.run_req  = 1'b0;
    intf.halt_req = 1'b0;
    intf.step_req = 1'b0;
  endtask

  task automatic applyStimulus(input bit r, input bit h, input bit s);
    intf.run_req  = r;
    intf.halt_req = h;
    intf.step_req = s;
    tick();
  endtask

  initial begin
    int c0;
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    intf.run_req   = 1'b0;
    intf.halt_req  = 1'b0;
    intf.step_req  = 1'b0;
    intf.speed_sel = 1'b0;
    intf.pc        = 4'd0;
    intf.bp_addr   = 4'd0;
    intf.bp_valid  = 1'b0;
    m_pc = 0;
    modelReset();
    repeat (3) @(negedge clock);
    checkOutput("rst core_en", intf.core_en, 0);
    checkOutput("rst halted", intf.halted, 1);
    checkOutput("rst running", intf.running, 0);
    checkOutput("rst step_count", intf.step_count, 0);
    checkOutput("rst bp_hit", intf.bp_hit, 0);
    reset = 1'b1;

    repeat (20) tick();
    checkOutput("idle step_count", intf.step_count, 0);
    checkOutput("idle halted", intf.halted, 1);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1);
      checkOutput("step pulse", intf.core_en, 1);
      repeat (4) tick();
    end
    checkOutput("steps count", intf.step_count, 3);
    checkOutput("steps halted", intf.halted, 1);

    intf.speed_sel = 1'b0;
    applyStimulus(1, 0, 0);
    repeat (16) tick();
    checkOutput("slow run count", intf.step_count, 7);
    intf.speed_sel = 1'b1;
    repeat (8) tick();
    checkOutput("fast run count", intf.step_count, 11);

    applyStimulus(0, 1, 0);
    intf.speed_sel = 1'b0;
    applyStimulus(1, 0, 0);
    repeat (3) tick();
    applyStimulus(0, 1, 0);
    checkOutput("halt at fire", intf.core_en, 0);
    checkOutput("halt at fire halted", intf.halted, 1);
    applyStimulus(1, 1, 0);
    checkOutput("run+halt halted", intf.halted, 1);
    tick();

`ifdef TD4_BREAKPOINT_EN
    intf.speed_sel = 1'b1;
    intf.bp_addr   = 4'd5;
    intf.bp_valid  = 1'b1;
    m_pc    = 0;
    intf.pc = 4'd0;
    c0 = m_count;
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 40 && m_mode != M_HALT; i++) tick();
    checkOutput("bp halted", intf.halted, 1);
    checkOutput("bp hit", intf.bp_hit, 1);
    checkOutput("bp enables", 32'(intf.step_count - 8'(c0)), 5);
    applyStimulus(1, 0, 0);
    checkOutput("bp rerun clear", intf.bp_hit, 0);
    repeat (3) tick();
    applyStimulus(0, 1, 0);
    intf.bp_valid = 1'b0;
`else
    c0 = 0;
`endif

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) intf.speed_sel = ~intf.speed_sel;
      intf.bp_valid = ($urandom_range(0, 3) == 0);
      intf.bp_addr  = 4'($urandom_range(0, 15));
      applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 7) == 0);
    end
    intf.bp_valid = 1'b0;

    applyStimulus(0, 1, 0);
    intf.speed_sel = 1'b1;
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 1200 && m_count != 254; i++) tick();
    checkOutput("reach 254", intf.step_count, 254);
    applyStimulus(0, 1, 0);
    tick();
    applyStimulus(0, 0, 1);
    checkOutput("wrap 255", intf.step_count, 255);
    tick();
    applyStimulus(0, 0, 1);
    checkOutput("wrap 0", intf.step_count, 0);
    tick();
    applyStimulus(0, 0, 1);
    checkOutput("wrap 1", intf.step_count, 1);
    tick();

    applyStimulus(1, 0, 0);
    for (int i = 0; i < 10 && !m_en; i++) tick();
    checkOutput("pre-reset core_en", intf.core_en, 1);
    #2 reset = 1'b0;
    #1;
    checkOutput("async core_en", intf.core_en, 0);
    checkOutput("async halted", intf.halted, 1);
    modelReset();
    @(negedge clock);
    reset = 1'b1;
    repeat (5) tick();
    checkOutput("post reset halted", intf.halted, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
